// File: rtl/trellis_pkg.sv
// Shared constants, FSM encoding and helper functions for the 8-state
// max-log-MAP metric recursion.
package trellis_pkg;

   localparam int NSTATES = 8;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} fsm_t;

   // Bit s set: state s uses branch2 (BR_SEL), or takes a negative sign (SIGN).
   localparam logic [7:0] BR_SEL = 8'b0110_0110;
   localparam logic [7:0] SIGN   = 8'b0101_1010;

   function automatic int pred0(input int s);
      return 2 * (s % 4);
   endfunction

   function automatic int pred1(input int s);
      return 2 * (s % 4) + 1;
   endfunction

   function automatic int succ0(input int p);
      return p / 2;
   endfunction

   function automatic int succ1(input int p);
      return p / 2 + 4;
   endfunction

   function automatic logic signed [63:0] neg_init(input int w);
      return -(64'sd1 <<< (w - 2));
   endfunction

   // a - b clamped to the signed range of a w-bit value
   function automatic logic signed [63:0] sat_sub(input logic signed [63:0] a,
                                                  input logic signed [63:0] b,
                                                  input int w);
      logic signed [63:0] d, hi, lo;
      d  = a - b;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (d > hi) return hi;
      if (d < lo) return lo;
      return d;
   endfunction

endpackage

// File: rtl/trellis_recursion_engine_if.sv
// Branch-pair input stream and metric-vector output stream of the engine.
interface trellis_recursion_engine_if #(
   parameter int DWIDTH = 16,
   parameter int LWIDTH = 12
);
   logic                     s_valid;
   logic                     s_ready;
   logic signed [DWIDTH-1:0] s_branch1;
   logic signed [DWIDTH-1:0] s_branch2;
   logic                     s_last;
   logic                     m_valid;
   logic                     m_ready;
   logic [8*DWIDTH-1:0]      m_metrics;
   logic [LWIDTH-1:0]        m_index;
   logic                     m_last;

   // slave: the engine's view; master: producer + consumer side
   modport slave  (input  s_valid, s_branch1, s_branch2, s_last, m_ready,
                   output s_ready, m_valid, m_metrics, m_index, m_last);
   modport master (output s_valid, s_branch1, s_branch2, s_last, m_ready,
                   input  s_ready, m_valid, m_metrics, m_index, m_last);
endinterface

// File: rtl/trellis_acs_unit.sv
// Two-input add-compare-select: max(m0 +/- br0, m1 +/- br1) in DWIDTH+2 bits.
module trellis_acs_unit #(
   parameter int DWIDTH = 16
) (
   input  logic signed [DWIDTH-1:0] m0,
   input  logic signed [DWIDTH-1:0] br0,
   input  logic                     neg0,
   input  logic signed [DWIDTH-1:0] m1,
   input  logic signed [DWIDTH-1:0] br1,
   input  logic                     neg1,
   output logic signed [DWIDTH+1:0] acs
);
   localparam int AW = DWIDTH + 2;

   logic signed [AW-1:0] t0, t1;

   always_comb begin
      t0  = neg0 ? (AW'(m0) - AW'(br0)) : (AW'(m0) + AW'(br0));
      t1  = neg1 ? (AW'(m1) - AW'(br1)) : (AW'(m1) + AW'(br1));
      acs = (t0 >= t1) ? t0 : t1;
   end
endmodule

// File: rtl/trellis_recursion_engine.sv
// Streaming alpha/beta state-metric recursion, one trellis step per accepted
// branch pair, normalised to state 0 and saturated to DWIDTH.
module trellis_recursion_engine #(
   parameter int DWIDTH  = 16,
   parameter int MAX_LEN = 3072,
   parameter int LWIDTH  = $clog2(MAX_LEN + 1),
   parameter int NSTATES = 8
) (
   input  logic                        aclk,
   input  logic                        aresetn,
   input  logic                        i_start,
   input  logic                        i_dir,
   input  logic                        i_term,
   input  logic [LWIDTH-1:0]           i_len,
   trellis_recursion_engine_if.slave   bus,
   output logic                        o_busy,
   output logic                        o_done,
   output logic                        o_err
);
   import trellis_pkg::*;

   if (NSTATES != trellis_pkg::NSTATES) begin : g_bad_nstates
      $error("trellis_recursion_engine: NSTATES must be 8");
   end

   localparam int AW = DWIDTH + 2;
   localparam logic [DWIDTH-1:0] NEG = DWIDTH'(neg_init(DWIDTH));

   fsm_t                          st, st_nxt;
   logic                          dir_q, err_q, vld_q, last_q;
   logic [LWIDTH-1:0]             len_q, k_q, idx_q;
   logic [NSTATES-1:0][DWIDTH-1:0] met_q, nxt, br;
   logic [NSTATES-1:0][AW-1:0]     fwd, bwd, sel;
   logic                          fire, at_last, start_ok;

   assign bus.s_ready   = (st == RUN) && (!vld_q || bus.m_ready);
   assign fire          = bus.s_valid && bus.s_ready;
   assign at_last       = (k_q == len_q - LWIDTH'(1));
   assign start_ok      = (st == IDLE) && i_start;
   assign o_busy        = (st != IDLE);
   assign o_done        = (st == DRAIN) && vld_q && bus.m_ready;
   assign o_err         = err_q;
   assign bus.m_valid   = vld_q;
   assign bus.m_metrics = met_q;
   assign bus.m_index   = idx_q;
   assign bus.m_last    = last_q;

   for (genvar s = 0; s < NSTATES; s++) begin : g_state
      assign br[s] = BR_SEL[s] ? bus.s_branch2 : bus.s_branch1;

      trellis_acs_unit #(.DWIDTH(DWIDTH)) u_fwd (
         .m0  (met_q[pred0(s)]),
         .br0 (br[s]),
         .neg0(SIGN[s]),
         .m1  (met_q[pred1(s)]),
         .br1 (br[s]),
         .neg1(~SIGN[s]),
         .acs (fwd[s])
      );

      // odd predecessors see the successor's branch with flipped sign
      trellis_acs_unit #(.DWIDTH(DWIDTH)) u_bwd (
         .m0  (met_q[succ0(s)]),
         .br0 (br[succ0(s)]),
         .neg0(SIGN[succ0(s)] ^ (s % 2 == 1)),
         .m1  (met_q[succ1(s)]),
         .br1 (br[succ1(s)]),
         .neg1(SIGN[succ1(s)] ^ (s % 2 == 1)),
         .acs (bwd[s])
      );

      assign sel[s] = dir_q ? bwd[s] : fwd[s];
      assign nxt[s] = DWIDTH'(sat_sub(64'($signed(sel[s])), 64'($signed(sel[0])), DWIDTH));
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) st <= IDLE;
      else          st <= st_nxt;
   end

   always_comb begin
      st_nxt = st;
      case (st)
         IDLE:    if (i_start) st_nxt = RUN;
         RUN:     if (fire && at_last) st_nxt = DRAIN;
         DRAIN:   if (vld_q && bus.m_ready) st_nxt = IDLE;
         default: st_nxt = IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         dir_q  <= 1'b0;
         err_q  <= 1'b0;
         vld_q  <= 1'b0;
         last_q <= 1'b0;
         len_q  <= '0;
         k_q    <= '0;
         idx_q  <= '0;
         met_q  <= '0;
      end else begin
         if (start_ok) begin
            dir_q <= i_dir;
            len_q <= (i_len == '0) ? LWIDTH'(1) : i_len;
            k_q   <= '0;
            err_q <= 1'b0;
            for (int s = 0; s < NSTATES; s++)
               met_q[s] <= (i_term && s != 0) ? NEG : '0;
         end
         if (fire) begin
            met_q  <= nxt;
            vld_q  <= 1'b1;
            idx_q  <= k_q;
            last_q <= at_last;
            k_q    <= k_q + LWIDTH'(1);
            // framing follows the counter; s_last is only cross-checked
            if (bus.s_last != at_last) err_q <= 1'b1;
         end else if (vld_q && bus.m_ready) begin
            vld_q <= 1'b0;
         end
      end
   end
endmodule
